strike_detector: RTL
====================

# strike_detector

Sensor front-end for the whack-a-box game: conditions the three raw piezo/GPIO strike lines and hands one box-strike event at a time to the scoring datapath over a valid/ready handshake. It owns synchronization, per-channel debounce, simultaneous-strike arbitration, a single-entry output buffer and a post-strike lockout. It sits between the GPIO pins and the game datapath, which compares `hit_box` against the LFSR target.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 50000: consecutive cycles a level must persist before it is accepted (1 ms at 50 MHz); must be at least 1.
- `LOCKOUT_CYCLES`, default 5000000: dead time after each consumed strike (100 ms at 50 MHz); 0 is legal.

Ports:
- `clk` in, 1: system clock (CLOCK_50).
- `reset` in, 1: asynchronous, active-high.
- `enable` in, 1: game running; low suppresses new strikes.
- `sensor_raw` in, 3: asynchronous strike lines, bit i = box i, active-high.
- `hit_valid` out, 1: strike event pending.
- `hit_box` out, 2: index of the struck box, 0..2; valid while `hit_valid`.
- `hit_ready` in, 1: consumer accepts the event.
- `sensor_level` out, 3: debounced levels, for the LEDs.
- `drop_count` out, 8: count of discarded strikes, saturating.

## Operation
- Reset values: `hit_valid`=0, `hit_box`=0, `sensor_level`=0, `drop_count`=0, all counters 0, FSM=ARMED.
  - Reset mid-operation discards any pending event and lockout.
- Synchronizer: each `sensor_raw` bit passes through two flops (reset 0), giving `sync[i]`.
- Debounce (per channel):
  - The counter clears in any cycle where `sync[i]` equals `sensor_level[i]`, otherwise it increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and a mismatch is present, `sensor_level[i]` toggles and the counter clears.
  - The counter is `$clog2(DEBOUNCE_CYCLES+1)` bits wide.
  - Debounce runs regardless of `enable` and FSM state.
- Strike: a 0→1 transition of `sensor_level[i]`, detected against a one-cycle-delayed copy. Falling transitions are never events.
- Arbitration: if several strikes occur in the same cycle, the lowest index wins. Each losing strike increments `drop_count` by one, saturating at 255.
- FSM:
  - ARMED: a strike with `enable`=1 registers `hit_box` and sets `hit_valid`, then → HOLD.
  - HOLD: `hit_valid`=1 and `hit_box` are stable.
    - On `hit_valid`&&`hit_ready`: clear `hit_valid`, load the lockout counter with LOCKOUT_CYCLES, then → LOCKOUT (→ ARMED directly if LOCKOUT_CYCLES=0).
  - LOCKOUT: decrements each cycle and → ARMED on the edge where the counter reaches 0. This gives exactly LOCKOUT_CYCLES cycles in LOCKOUT.
- Drops:
  - With `enable`=1, any strike arriving in HOLD or LOCKOUT is discarded. This includes the edge on which HOLD→LOCKOUT occurs.
  - Each discarded strike increments `drop_count`, saturating.
  - Strikes with `enable`=0 are ignored and not counted.
- `enable` falling does not cancel a pending event or an active lockout.
- `hit_ready` is ignored unless `hit_valid`=1.

## Timing
- Raw-to-event latency: with `sensor_raw[i]` rising before edge 0 and held, `sensor_level[i]` rises after edge DEBOUNCE_CYCLES+1. `hit_valid` rises after edge DEBOUNCE_CYCLES+2, i.e. DEBOUNCE_CYCLES+3 edges counting edge 0.
- Glitch rejection: a raw pulse shorter than DEBOUNCE_CYCLES cycles (as seen at `sync`) never changes `sensor_level`.
- Handshake: the transfer occurs on the edge where `hit_valid`&&`hit_ready`. `hit_valid` is low the next cycle. There is no combinational path from `hit_ready` to `hit_valid`.
- Minimum spacing between consecutive events is 1 + LOCKOUT_CYCLES cycles after the handshake edge. A strike detected in the first ARMED cycle is accepted.
- All outputs are registered.

## Test plan
Use DEBOUNCE_CYCLES=4 and LOCKOUT_CYCLES=10 unless stated otherwise.

1. Single strike, `hit_ready` tied 1: `sensor_raw`=001 held from edge 0 → `hit_valid`=1, `hit_box`=0 after edge 6, for exactly one cycle. `sensor_level`=001 after edge 5.
2. Glitch rejection: `sensor_raw[2]` pulsed for 3 cycles → `sensor_level` stays 000, `hit_valid` never rises, `drop_count`=0.
3. Simultaneous strike: `sensor_raw` 000→110 in one cycle → a single event with `hit_box`=1, `drop_count`=1.
4. Backpressure and lockout: strike on box 2 with `hit_ready`=0 for 20 cycles → `hit_valid` and `hit_box`=2 held throughout.
   - A box-0 strike during HOLD → `drop_count`=1.
   - Pulse `hit_ready` → `hit_valid` drops.
   - A box-1 strike debounced 5 cycles later → dropped, `drop_count`=2.
   - A box-1 strike after 10 lockout cycles → event `hit_box`=1.
5. Enable gating: `enable`=0 with a box-0 strike → no event, `drop_count` unchanged, `sensor_level[0]`=1. Setting `enable`=1 while still pressed → no event (no new rising edge).
6. Reset mid-HOLD: assert `reset` asynchronously while `hit_valid`=1 → `hit_valid`, `hit_box`, `sensor_level` and `drop_count` go to 0 immediately, without waiting for a clock edge. After release, a new strike produces an event with nominal latency. Also with `drop_count` forced to 255 plus one further drop → it stays at 255.

Source files
------------

// File: rtl/strike_detector.sv
// Strike-sensor front-end: synchronizes and debounces three strike lines, then
// arbitrates rising edges into a single-entry valid/ready event buffer with post-strike lockout.
`timescale 1ns/1ps

module strike_detector #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LOCKOUT_CYCLES  = 5000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [2:0] sensor_raw,
  output logic       hit_valid,
  output logic [1:0] hit_box,
  input  logic       hit_ready,
  output logic [2:0] sensor_level,
  output logic [7:0] drop_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES);

  typedef enum logic [1:0] {
    ARMED,
    HOLD,
    LOCKOUT
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        sync_meta, sync;
  logic [2:0][DW-1:0] db_cnt;
  logic [2:0]        level_d;
  logic [2:0]        rise;
  logic [1:0]        n_rise;
  logic [1:0]        n_drop;
  logic [1:0]        winner;
  logic [8:0]        drop_sum;
  logic [LW-1:0]     lock_cnt, lock_d;
  logic              hit_valid_d;
  logic [1:0]        hit_box_d;
  logic [7:0]        drop_d;

  // Two-flop synchronizer on the asynchronous strike lines.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= sensor_raw;
      sync      <= sync_meta;
    end
  end

  // A level is accepted only after DEBOUNCE_CYCLES consecutive mismatching cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt       <= '0;
      sensor_level <= '0;
      level_d      <= '0;
    end else begin
      level_d <= sensor_level;
      for (int i = 0; i < 3; i++) begin
        if (sync[i] == sensor_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          sensor_level[i] <= ~sensor_level[i];
          db_cnt[i]       <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign rise = sensor_level & ~level_d;

  // NOTE: every signal written here gets a default first, so no latches are inferred.
  always_comb begin
    state_d     = state_q;
    hit_valid_d = hit_valid;
    hit_box_d   = hit_box;
    lock_d      = lock_cnt;
    n_drop      = 2'd0;
    n_rise      = 2'(rise[0]) + 2'(rise[1]) + 2'(rise[2]);

    if (rise[0])      winner = 2'd0;
    else if (rise[1]) winner = 2'd1;
    else              winner = 2'd2;

    case (state_q)
      ARMED: begin
        if (enable && (rise != 3'b000)) begin
          hit_valid_d = 1'b1;
          hit_box_d   = winner;
          n_drop      = n_rise - 2'd1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (enable) n_drop = n_rise;
        if (hit_valid && hit_ready) begin
          hit_valid_d = 1'b0;
          lock_d      = LOCK_LOAD;
          state_d     = (LOCKOUT_CYCLES == 0) ? ARMED : LOCKOUT;
        end
      end
      LOCKOUT: begin
        if (enable) n_drop = n_rise;
        lock_d = lock_cnt - LW'(1);
        if (lock_cnt == LW'(1)) state_d = ARMED;
      end
      default: state_d = ARMED;
    endcase

    // Losing or late strikes are tallied, saturating at 255.
    drop_sum = {1'b0, drop_count} + 9'(n_drop);
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARMED;
      hit_valid  <= 1'b0;
      hit_box    <= 2'd0;
      lock_cnt   <= '0;
      drop_count <= 8'd0;
    end else begin
      state_q    <= state_d;
      hit_valid  <= hit_valid_d;
      hit_box    <= hit_box_d;
      lock_cnt   <= lock_d;
      drop_count <= drop_d;
    end
  end

endmodule
